// File: rtl/mem_bus_arbiter.sv
// Two-port req/ack arbiter in front of a single 8-bit memory port, sequenced IDLE -> ACCESS -> RESP.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie instead of round-robin.
module mem_bus_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_r;
    logic   we_r;
    logic   win_s;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Winner selection: port 0 takes every tie.
    always_comb begin
        win_s = 1'b0;
        if (req0) begin
            win_s = 1'b0;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end
`else
    logic last_gnt_r;

    // Winner selection: a tie goes to the port that was not granted last.
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
            win_s = ~last_gnt_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Round-robin history, updated at every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_r <= 1'b1;
        end else if (state_r == IDLE && (req0 || req1)) begin
            last_gnt_r <= win_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`endif

    // Transfer sequencer; every output is a register so the memory sees glitch-free strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            we_r      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= {DW{1'b0}};
            rdata1    <= {DW{1'b0}};
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            mem_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        gnt0      <= ~win_s;
                        gnt1      <= win_s;
                        mem_addr  <= win_s ? addr1 : addr0;
                        mem_wdata <= win_s ? wdata1 : wdata0;
                        mem_we    <= win_s ? we1 : we0;
                        we_r      <= win_s ? we1 : we0;
                        busy      <= 1'b1;
                        state_r   <= ACCESS;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    // Memory read data is combinational from mem_addr, so it is valid at this edge.
                    if (!we_r && gnt1) begin
                        rdata1 <= mem_rdata;
                    end else if (!we_r && gnt0) begin
                        rdata0 <= mem_rdata;
                    end else begin
                        rdata0 <= rdata0;
                    end
                    ack0    <= gnt0;
                    ack1    <= gnt1;
                    state_r <= RESP;
                end
                RESP: begin
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    mem_addr  <= {AW{1'b0}};
                    mem_wdata <= {DW{1'b0}};
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= {AW{1'b0}};
                    mem_wdata <= {DW{1'b0}};
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a behavioural 256x8 memory behind it.
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, ack0, ack1, mem_we, busy;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [0:255];
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory array: DUT writes, plus a backdoor used only while the DUT is held in reset.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    mem_bus_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] rq;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        preload(8'h05, 8'hA3);
        preload(8'hFF, 8'h3C);
        preload(8'h20, 8'h11);
        for (int i = 0; i < 4; i++) begin
            rq = i[1:0];
            req0 = rq[0]; req1 = rq[1];
            tick();
            checks++;
            if ({gnt0, gnt1, ack0, ack1, busy, mem_we, mem_addr, mem_wdata, rdata0, rdata1} !== 38'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h required 0", i,
                         {gnt0, gnt1, ack0, ack1, busy, mem_we, mem_addr, mem_wdata, rdata0, rdata1});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got gnt/busy=%b required 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_read();
        addr0 = 8'h05; we0 = 1'b0; req0 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy, mem_we} !== 6'b100010 || mem_addr !== 8'h05) begin
            errors++;
            $display("FAIL read_access: got flags=%b addr=%h required 100010 05",
                     {gnt0, gnt1, ack0, ack1, busy, mem_we}, mem_addr);
        end
        tick();
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy, mem_we} !== 6'b101010 || rdata0 !== 8'hA3 || mem_addr !== 8'h05) begin
            errors++;
            $display("FAIL read_resp: got flags=%b rdata0=%h addr=%h required 101010 A3 05",
                     {gnt0, gnt1, ack0, ack1, busy, mem_we}, rdata0, mem_addr);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy, mem_we} !== 6'b000000 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL read_back_idle: got flags=%b addr=%h required 000000 00",
                     {gnt0, gnt1, ack0, ack1, busy, mem_we}, mem_addr);
        end
        addr0 = 8'hFF; req0 = 1'b1;
        tick();
        tick();
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 8'h3C) begin
            errors++;
            $display("FAIL read_top_addr: got ack0=%b rdata0=%h required 1 3C", ack0, rdata0);
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        addr1 = 8'h10; wdata1 = 8'h5C; we1 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy, mem_we} !== 6'b010011 || mem_addr !== 8'h10 || mem_wdata !== 8'h5C) begin
            errors++;
            $display("FAIL write_access: got flags=%b addr=%h wdata=%h required 010011 10 5C",
                     {gnt0, gnt1, ack0, ack1, busy, mem_we}, mem_addr, mem_wdata);
        end
        addr1 = 8'h99; wdata1 = 8'h00; we1 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy, mem_we} !== 6'b010110 || mem_addr !== 8'h10 ||
            rdata1 !== 8'h00 || mem[8'h10] !== 8'h5C) begin
            errors++;
            $display("FAIL write_resp: got flags=%b addr=%h rdata1=%h mem=%h required 010110 10 00 5C",
                     {gnt0, gnt1, ack0, ack1, busy, mem_we}, mem_addr, rdata1, mem[8'h10]);
        end
        req1 = 1'b0;
        tick();
        addr1 = 8'h10; we1 = 1'b0; req1 = 1'b1;
        tick();
        tick();
        checks++;
        if (ack1 !== 1'b1 || rdata1 !== 8'h5C || rdata0 !== 8'h3C) begin
            errors++;
            $display("FAIL write_then_read: got ack1=%b rdata1=%h rdata0=%h required 1 5C 3C",
                     ack1, rdata1, rdata0);
        end
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic       w;
        logic [3:0] exp;
        rst = 1'b0;
        addr0 = 8'h05; we0 = 1'b0; addr1 = 8'h10; we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ((k / 3) % 2) == 1;
`endif
            case (k % 3)
                0:       exp = w ? 4'b0100 : 4'b1000;
                1:       exp = w ? 4'b0101 : 4'b1010;
                default: exp = 4'b0000;
            endcase
            checks++;
            if ({gnt0, gnt1, ack0, ack1} !== exp) begin
                errors++;
                $display("FAIL contention_cycle[%0d]: got gnt0,gnt1,ack0,ack1=%b required %b",
                         k, {gnt0, gnt1, ack0, ack1}, exp);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (rdata0 !== 8'hA3 || rdata1 !== 8'h00) begin
`else
        if (rdata0 !== 8'hA3 || rdata1 !== 8'h5C) begin
`endif
            errors++;
            $display("FAIL contention_rdata: got rdata0=%h rdata1=%h", rdata0, rdata1);
        end
    endtask

    task automatic test_abort();
        addr0 = 8'h20; wdata0 = 8'h77; we0 = 1'b1; req0 = 1'b1;
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h20) begin
            errors++;
            $display("FAIL abort_access: got mem_we=%b addr=%h required 1 20", mem_we, mem_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_async_drop: got mem_we=%b busy=%b gnt0=%b required 0 0 0", mem_we, busy, gnt0);
        end
        req0 = 1'b0; we0 = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ack0, ack1, busy, gnt0, gnt1} !== 5'b00000) begin
                errors++;
                $display("FAIL abort_no_ack[%0d]: got ack0,ack1,busy,gnt0,gnt1=%b required 00000",
                         i, {ack0, ack1, busy, gnt0, gnt1});
            end
        end
        checks++;
        if (mem[8'h20] !== 8'h11) begin
            errors++;
            $display("FAIL abort_mem_untouched: got %h required 11", mem[8'h20]);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_contention();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
